// File: rtl/ccr_branch_unit.sv
// ---------------------------------------------------------------------------
// ccr_branch_unit
//
// Condition-code register (Z/N/C) plus the jump resolution logic that sits
// next to it in the execute stage. Jump conditions are evaluated against the
// "effective" flags: the current CCR with any same-cycle ALU write and
// set/clear-carry applied. This lets a flag-setting instruction and a dependent
// jump resolve without a bubble. A taken jump produces a one-cycle registered
// branch_taken pulse with its target, and holds flush high for FLUSH_CYCLES
// non-stalled cycles so the younger fetch/decode instructions are squashed.
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-low reset
//   alu_flags[2:0] ALU flags from execute: [0]=Z, [1]=N, [2]=C
//   flag_wr_en     execute-stage instruction writes flags this cycle
//   flag_mask[2:0] per-bit write enable for alu_flags
//   setc / clrc    force C to 1 / 0 (setc has priority)
//   jmp_valid      jump instruction present this cycle
//   jmp_type[1:0]  00 JMP, 01 JZ, 10 JN, 11 JC
//   jmp_target     jump destination address
//   int_save       copy effective flags into the interrupt shadow register
//   rti_restore    reload CCR from the interrupt shadow register
//   stall          pipeline freeze; every register holds
//   ccr[2:0]       architectural flag register
//   saved_ccr[2:0] interrupt shadow copy of the flags
//   branch_taken   registered one-cycle pulse for a taken jump
//   branch_target  registered target, valid while branch_taken=1
//   flush          squash for fetch/decode, high exactly while in FLUSH
// ---------------------------------------------------------------------------
module ccr_branch_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        alu_flags,
  input  logic              flag_wr_en,
  input  logic [2:0]        flag_mask,
  input  logic              setc,
  input  logic              clrc,
  input  logic              jmp_valid,
  input  logic [1:0]        jmp_type,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              int_save,
  input  logic              rti_restore,
  input  logic              stall,
  output logic [2:0]        ccr,
  output logic [2:0]        saved_ccr,
  output logic              branch_taken,
  output logic [ADDR_W-1:0] branch_target,
  output logic              flush
);

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;
  logic [2:0]          ccr_q, ccr_d;
  logic [2:0]          saved_q, saved_d;
  logic                taken_q, taken_d;
  logic [ADDR_W-1:0]   target_q, target_d;

  logic                accept;      // instructions in execute are live (not squashed)
  logic [2:0]          wr_merged;   // ccr with the masked ALU write applied
  logic [2:0]          eff;         // effective flags seen by jumps and saves
  logic                cond_met;
  logic                jump_taken;
  logic [2:0]          clr_mask;    // flag tested by a conditional jump

  assign accept = (state_q == ST_IDLE);

  // Per-bit masked ALU write; squashed while flushing.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_flag_wr
      assign wr_merged[gi] = (accept && flag_wr_en && flag_mask[gi]) ? alu_flags[gi]
                                                                     : ccr_q[gi];
    end
  endgenerate

  always_comb begin
    eff = wr_merged;
    if (accept) begin
      if (setc) begin
        eff[2] = 1'b1;
      end else if (clrc) begin
        eff[2] = 1'b0;
      end
    end
  end

  always_comb begin
    cond_met = 1'b0;
    clr_mask = 3'b000;
    case (jmp_type)
      2'b00: begin cond_met = 1'b1;   clr_mask = 3'b000; end
      2'b01: begin cond_met = eff[0]; clr_mask = 3'b001; end
      2'b10: begin cond_met = eff[1]; clr_mask = 3'b010; end
      default: begin cond_met = eff[2]; clr_mask = 3'b100; end
    endcase
  end

  assign jump_taken = jmp_valid && accept && !stall && cond_met;

  // Next-state and next-register logic. Everything holds under stall;
  // the branch pulse is simply not regenerated, so it cannot stretch.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ccr_d    = ccr_q;
    saved_d  = saved_q;
    taken_d  = jump_taken;
    target_d = target_q;

    if (!stall) begin
      // rti reads the old shadow value even when int_save overwrites it now.
      if (rti_restore) begin
        ccr_d = saved_q;
      end else if (jump_taken) begin
        ccr_d = eff & ~clr_mask;
      end else begin
        ccr_d = eff;
      end

      if (int_save) begin
        saved_d = eff;
      end

      if (jump_taken) begin
        target_d = jmp_target;
      end

      case (state_q)
        ST_IDLE: begin
          if (jump_taken) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LOAD;
          end
        end
        ST_FLUSH: begin
          if (cnt_q <= 3'd1) begin
            state_d = ST_IDLE;
            cnt_d   = 3'd0;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 3'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      ccr_q    <= 3'b000;
      saved_q  <= 3'b000;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ccr_q    <= ccr_d;
      saved_q  <= saved_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  assign ccr           = ccr_q;
  assign saved_ccr     = saved_q;
  assign branch_taken  = taken_q;
  assign branch_target = target_q;
  assign flush         = (state_q == ST_FLUSH);

endmodule

// File: tb/tb_ccr_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_ccr_branch_unit
//
// Directed bench for ccr_branch_unit (FLUSH_CYCLES=2, ADDR_W=16). Inputs are
// driven 1 time unit after a rising edge; outputs are checked 1 time unit
// after the following edge. Expected values are hand-computed per step.
// ---------------------------------------------------------------------------
module tb_ccr_branch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  alu_flags;
  logic        flag_wr_en;
  logic [2:0]  flag_mask;
  logic        setc;
  logic        clrc;
  logic        jmp_valid;
  logic [1:0]  jmp_type;
  logic [15:0] jmp_target;
  logic        int_save;
  logic        rti_restore;
  logic        stall;
  logic [2:0]  ccr;
  logic [2:0]  saved_ccr;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        flush;

  int total = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ccr_branch_unit #(.FLUSH_CYCLES(2), .ADDR_W(16)) dut (
    .clk(clk), .rst(rst),
    .alu_flags(alu_flags), .flag_wr_en(flag_wr_en), .flag_mask(flag_mask),
    .setc(setc), .clrc(clrc),
    .jmp_valid(jmp_valid), .jmp_type(jmp_type), .jmp_target(jmp_target),
    .int_save(int_save), .rti_restore(rti_restore), .stall(stall),
    .ccr(ccr), .saved_ccr(saved_ccr),
    .branch_taken(branch_taken), .branch_target(branch_target), .flush(flush)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    alu_flags = 3'b000; flag_wr_en = 1'b0; flag_mask = 3'b000;
    setc = 1'b0; clrc = 1'b0;
    jmp_valid = 1'b0; jmp_type = 2'b00; jmp_target = 16'h0000;
    int_save = 1'b0; rti_restore = 1'b0; stall = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic flag_write(input logic [2:0] val, input logic [2:0] mask);
    flag_wr_en = 1'b1; alu_flags = val; flag_mask = mask;
  endtask

  task automatic jump(input logic [1:0] t, input logic [15:0] tgt);
    jmp_valid = 1'b1; jmp_type = t; jmp_target = tgt;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog expired before end of sequence");
    $fatal(1, "timeout");
  end

  initial begin
    idle_inputs();
    rst = 1'b0;
    #12;
    // Reset state
    chk("rst_ccr", 32'(ccr), 32'h0);
    chk("rst_saved", 32'(saved_ccr), 32'h0);
    chk("rst_taken", 32'(branch_taken), 32'h0);
    chk("rst_target", 32'(branch_target), 32'h0);
    chk("rst_flush", 32'(flush), 32'h0);
    rst = 1'b1;
    $display("reset released");

    // Flag write Z=1
    flag_write(3'b001, 3'b111);
    step(); idle_inputs();
    chk("wr_ccr", 32'(ccr), 32'h1);
    chk("wr_taken", 32'(branch_taken), 32'h0);
    $display("flag write: ccr=%b", ccr);

    // JZ taken, Z cleared, flush for 2 cycles
    jump(2'b01, 16'h00A4);
    step(); idle_inputs();
    chk("jz_taken", 32'(branch_taken), 32'h1);
    chk("jz_target", 32'(branch_target), 32'h00A4);
    chk("jz_ccr", 32'(ccr), 32'h0);
    chk("jz_flush1", 32'(flush), 32'h1);
    step();
    chk("jz_pulse_end", 32'(branch_taken), 32'h0);
    chk("jz_flush2", 32'(flush), 32'h1);
    step();
    chk("jz_flush_done", 32'(flush), 32'h0);
    $display("JZ: target=%h", branch_target);

    // JC taken through same-cycle bypass of C; C cleared afterwards
    flag_write(3'b100, 3'b100);
    jump(2'b11, 16'h1234);
    step(); idle_inputs();
    chk("jc_taken", 32'(branch_taken), 32'h1);
    chk("jc_target", 32'(branch_target), 32'h1234);
    chk("jc_ccr", 32'(ccr), 32'h0);
    step(); step();
    chk("jc_flush_done", 32'(flush), 32'h0);
    $display("JC bypass: ccr=%b", ccr);

    // JMP then JZ (with Z=1) inside flush: JZ and flag write squashed
    flag_write(3'b001, 3'b111);
    step(); idle_inputs();
    chk("pre_jmp_ccr", 32'(ccr), 32'h1);
    jump(2'b00, 16'h0BEE);
    step(); idle_inputs();
    chk("jmp_taken", 32'(branch_taken), 32'h1);
    chk("jmp_ccr", 32'(ccr), 32'h1);
    jump(2'b01, 16'h0555);
    flag_write(3'b000, 3'b111);
    setc = 1'b1;
    step(); idle_inputs();
    chk("sq_taken", 32'(branch_taken), 32'h0);
    chk("sq_target", 32'(branch_target), 32'h0BEE);
    chk("sq_ccr", 32'(ccr), 32'h1);
    chk("sq_flush", 32'(flush), 32'h1);
    step();
    chk("sq_taken2", 32'(branch_taken), 32'h0);
    chk("sq_flush_done", 32'(flush), 32'h0);
    $display("JMP then squashed JZ: ccr=%b", ccr);

    // Interrupt save / modify / restore
    flag_write(3'b110, 3'b111);
    step(); idle_inputs();
    chk("int_pre_ccr", 32'(ccr), 32'h6);
    int_save = 1'b1;
    step(); idle_inputs();
    chk("int_saved", 32'(saved_ccr), 32'h6);
    clrc = 1'b1;
    step(); idle_inputs();
    chk("clrc_ccr", 32'(ccr), 32'h2);
    flag_write(3'b001, 3'b001);
    step(); idle_inputs();
    chk("int_wr_ccr", 32'(ccr), 32'h3);
    rti_restore = 1'b1;
    step(); idle_inputs();
    chk("rti_ccr", 32'(ccr), 32'h6);
    chk("rti_saved", 32'(saved_ccr), 32'h6);
    $display("save/restore: ccr=%b saved=%b", ccr, saved_ccr);

    // Simultaneous save+restore uses the old shadow value
    flag_write(3'b001, 3'b111);
    step(); idle_inputs();
    int_save = 1'b1; rti_restore = 1'b1;
    step(); idle_inputs();
    chk("both_ccr", 32'(ccr), 32'h6);
    chk("both_saved", 32'(saved_ccr), 32'h1);

    // setc wins over clrc
    clrc = 1'b1;
    step(); idle_inputs();
    chk("clrc2_ccr", 32'(ccr), 32'h2);
    setc = 1'b1; clrc = 1'b1;
    step(); idle_inputs();
    chk("setc_wins", 32'(ccr), 32'h6);
    $display("setc/clrc: ccr=%b", ccr);

    // JN taken clears N; then JZ with Z=0 not taken
    jump(2'b10, 16'h00FF);
    step(); idle_inputs();
    chk("jn_taken", 32'(branch_taken), 32'h1);
    chk("jn_ccr", 32'(ccr), 32'h4);
    step(); step();
    jump(2'b01, 16'h0F0F);
    step(); idle_inputs();
    chk("jz_nt_taken", 32'(branch_taken), 32'h0);
    chk("jz_nt_flush", 32'(flush), 32'h0);
    chk("jz_nt_ccr", 32'(ccr), 32'h4);
    $display("JN taken / JZ not taken: ccr=%b", ccr);

    // Stall for 3 cycles in FLUSH; restore is held off by stall
    jump(2'b00, 16'h0777);
    step(); idle_inputs();
    chk("st_taken", 32'(branch_taken), 32'h1);
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; rti_restore = 1'b1;
      step();
      chk("st_flush_hold", 32'(flush), 32'h1);
      chk("st_no_pulse", 32'(branch_taken), 32'h0);
      chk("st_ccr_hold", 32'(ccr), 32'h4);
    end
    idle_inputs();
    step();
    chk("st_flush_last", 32'(flush), 32'h1);
    step();
    chk("st_flush_done", 32'(flush), 32'h0);
    $display("stall in flush: ccr=%b", ccr);

    // Asynchronous reset mid-FLUSH, then a jump on the first edge
    jump(2'b00, 16'h0999);
    step(); idle_inputs();
    chk("ar_flush_on", 32'(flush), 32'h1);
    #1 rst = 1'b0;
    #1;
    chk("ar_flush", 32'(flush), 32'h0);
    chk("ar_ccr", 32'(ccr), 32'h0);
    chk("ar_target", 32'(branch_target), 32'h0);
    chk("ar_saved", 32'(saved_ccr), 32'h0);
    #1 rst = 1'b1;
    jump(2'b00, 16'h0042);
    step(); idle_inputs();
    chk("ar_jmp_taken", 32'(branch_taken), 32'h1);
    chk("ar_jmp_target", 32'(branch_target), 32'h0042);
    $display("reset mid-flush then jump: target=%h", branch_target);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule

// File: doc/ccr_branch_unit.md
CCR_BRANCH_UNIT -- requirements
Module: ccr_branch_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, giving the number of cycles flush is held after a taken jump (range 1..7).
REQ-002 SHALL have parameter ADDR_W, default 16, giving the jump-target width.
REQ-003 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port alu_flags  in  3  flags from the execute-stage ALU: [0]=Z, [1]=N, [2]=C.
REQ-006 SHALL have port flag_wr_en  in  1  the execute-stage instruction updates flags this cycle.
REQ-007 SHALL have port flag_mask  in  3  per-bit write enable for alu_flags, with the same bit order.
REQ-008 SHALL have ports setc and clrc  in  1 each  force C to 1 or 0.
REQ-009 SHALL have port jmp_valid  in  1  a jump instruction is presented this cycle.
REQ-010 SHALL have port jmp_type  in  2  jump condition: 00 JMP, 01 JZ, 10 JN, 11 JC.
REQ-011 SHALL have port jmp_target  in  ADDR_W  the jump destination.
REQ-012 SHALL have ports int_save and rti_restore  in  1 each  save CCR on interrupt entry, restore CCR on RTI.
REQ-013 SHALL have port stall  in  1  pipeline freeze.
REQ-014 SHALL have port ccr  out  3  the architectural flag register.
REQ-015 SHALL have port saved_ccr  out  3  the interrupt shadow copy of the flags.
REQ-016 SHALL have port branch_taken  out  1  registered one-cycle pulse indicating a taken jump.
REQ-017 SHALL have port branch_target  out  ADDR_W  registered target, valid while branch_taken=1.
REQ-018 SHALL have port flush  out  1  squash signal for the fetch and decode stages.

Function
REQ-019 SHALL compute the effective flags eff each cycle as: ccr with bits replaced by alu_flags where flag_wr_en & flag_mask, then C forced to 1 by setc or to 0 by clrc; setc wins if both are set.
REQ-020 SHALL evaluate jump conditions against eff, so a same-cycle ALU update is bypassed without a bubble.
REQ-021 SHALL treat a jump as taken when jmp_valid=1, state=IDLE, stall=0, and one of: type JMP; JZ with eff.Z=1; JN with eff.N=1; JC with eff.C=1.
REQ-022 SHALL clear the tested flag in the next ccr when a conditional jump is taken (JZ clears Z, JN clears N, JC clears C); JMP changes no flag.
REQ-023 SHALL select next ccr with priority rti_restore (load saved_ccr) > taken-jump clear applied to eff > eff.
REQ-024 SHALL load saved_ccr with eff when int_save=1; if int_save and rti_restore are both set, the restore into ccr uses the old saved_ccr.
REQ-025 SHALL register branch_taken=1 and branch_target=jmp_target one cycle after a taken jump, with branch_taken=1 for exactly one cycle.
REQ-026 SHALL implement the state machine IDLE -> FLUSH on a taken jump, load a counter with FLUSH_CYCLES, decrement the counter each non-stalled cycle in FLUSH, and return FLUSH -> IDLE when the counter reaches 1 and decrements.
REQ-027 SHALL drive flush=1 exactly while state=FLUSH, which starts in the same cycle as branch_taken.
REQ-028 SHALL ignore jmp_valid, flag_wr_en, setc and clrc while in FLUSH, because those instructions are squashed; int_save and rti_restore remain honoured.
REQ-029 SHALL hold all registers while stall=1 (ccr, saved_ccr, state, counter, branch_target), force branch_taken to 0, and not extend the pulse.
REQ-030 SHALL leave ccr unchanged when no update source is active.

Reset
REQ-031 SHALL, on rst=0 and independent of clk, force ccr=000, saved_ccr=000, branch_taken=0, branch_target=0, flush=0, state=IDLE, and counter=0.
REQ-032 SHALL, when reset is asserted mid-FLUSH, abandon the flush immediately and, after release, accept a jump on the first clock edge.

Verification
REQ-033 SHALL be verified by: reset, then flag_wr_en=1, mask=111, alu_flags=001 -> ccr=001 next cycle, branch_taken=0.
REQ-034 SHALL be verified by: ccr=001, JZ, target=0x00A4 -> branch_taken=1, branch_target=0x00A4, ccr=000, and flush high for 2 cycles.
REQ-035 SHALL be verified by: ccr=000, JC with same-cycle flag_wr_en, alu_flags=100, mask=100 -> taken by bypass, and ccr stays 000 because C is cleared.
REQ-036 SHALL be verified by: JMP taken, then JZ with Z=1 on the next cycle -> JZ ignored, ccr.Z unchanged, and only one branch_taken pulse.
REQ-037 SHALL be verified by: ccr=110 with int_save, then setc or clrc or a flag write, then rti_restore -> ccr=110 and saved_ccr=110.
REQ-038 SHALL be verified by: stall=1 for 3 cycles during FLUSH -> flush lasts 2 non-stalled cycles; then rst=0 mid-FLUSH -> flush=0 immediately and ccr=000.
